multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 57 +++++
 rtl/multicycle_controller_aludec.sv | 29 ++
 rtl/multicycle_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, funct
// fields, ALU controls and datapath mux selects.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU operation decode from the controller's aluop class and the R-type funct.
module aludec
   import multicycle_controller_pkg::*;
(
   input  logic [5:0] funct,
   input  logic [1:0] aluop,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               F_ADD:   alucontrol = ALU_ADD;
               F_SUB:   alucontrol = ALU_SUB;
               F_AND:   alucontrol = ALU_AND;
               F_OR:    alucontrol = ALU_OR;
               F_SLT:   alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects and enables.
//
// state      | meaning
// FETCH   0  | read instruction, PC <= PC+4 when memory is ready
// DECODE  1  | read registers, precompute branch target
// MEMADR  2  | compute lw/sw address
// MEMRD   3  | load data read, waits on mem_ready
// MEMWB   4  | write load data to register file
// MEMWR   5  | store data write, waits on mem_ready
// RTYPEEX 6  | R-type ALU operation
// RTYPEWB 7  | write R-type result to rd
// BEQEX   8  | compare and branch
// ADDIEX  9  | add immediate
// ADDIWB  10 | write addi result to rt
// JEX     11 | jump
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       pcen,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t     state_q;
   logic [1:0] aluop;
   logic       pcwrite;
   logic       branch;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
      end else begin
         case (state_q)
            S_FETCH:   if (mem_ready) state_q <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: state_q <= S_MEMADR;
                  OP_RTYPE:     state_q <= S_RTYPEEX;
                  OP_BEQ:       state_q <= S_BEQEX;
                  OP_ADDI:      state_q <= S_ADDIEX;
                  OP_J:         state_q <= S_JEX;
                  default:      state_q <= S_FETCH;
               endcase
            end
            S_MEMADR:  state_q <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_q <= S_MEMWB;
            S_MEMWR:   if (mem_ready) state_q <= S_FETCH;
            S_RTYPEEX: state_q <= S_RTYPEWB;
            S_ADDIEX:  state_q <= S_ADDIWB;
            default:   state_q <= S_FETCH;
         endcase
      end
   end

   // Moore decode of the state register; the only input-dependent terms are
   // the mem_ready handshake in FETCH/MEMWR and the illegal-op flag in DECODE.
   always_comb begin
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_REG;
      pcsrc      = PCSRC_ALU;
      aluop      = ALUOP_ADD;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrcb = SRCB_FOUR;
            irwrite = mem_ready & reset_n;
            pcwrite = mem_ready & reset_n;
         end
         S_DECODE: begin
            alusrcb    = SRCB_IMMSH;
            illegal_op = ~is_legal_op(op);
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite   = 1'b1;
            instr_done = mem_ready;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQEX: begin
            alusrca    = 1'b1;
            aluop      = ALUOP_SUB;
            pcsrc      = PCSRC_ALUOUT;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_ADDIWB: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_JEX: begin
            pcsrc      = PCSRC_JUMP;
            pcwrite    = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign pcen  = pcwrite | (branch & zero);
   assign state = state_q;

   aludec u_aludec (
      .funct      (funct),
      .aluop      (aluop),
      .alucontrol (alucontrol)
   );

endmodule
